snn_inference_ctrl: RTL and testbench

Sequencer for the spiking classifier. On a start pulse it clears the LIF network and readout counters, then holds the input spike pattern for a fixed number of timesteps. It drains the layer pipeline, then scans the per-class spike counters through a select/mux interface to find the winning class. It reports the result with a one-cycle done pulse and holds it until the next inference.

---
 rtl/snn_inference_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_snn_inference_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/snn_inference_ctrl.sv
// ---------------------------------------------------------------------------
// snn_inference_ctrl
//
// Sequencer for the spiking classifier. A start request clears the LIF
// network and its readout counters, then the latched input spike pattern is
// held on the input layer for NUM_STEPS timesteps. The layer pipeline is then
// drained for DRAIN_CYCLES timesteps with the stimulus zeroed. Finally the
// per-class spike counters are scanned through an external select/mux to
// find the winning class (ties go to the lowest index). The result is
// reported with a one-cycle done pulse and held until the next result.
//
// Ports:
//   clk_i        clock
//   rst_ni       asynchronous active-low reset
//   start_i      start request, honoured only while idle
//   abort_i      cancel a running inference (returns to idle, no done)
//   pattern_i    input spike pattern, latched on an accepted start
//   stim_o       pattern driven to the input layer (zero outside RUN)
//   net_en_o     network/counter advance enable (RUN and DRAIN)
//   net_clr_o    synchronous clear of membranes and spike counters (CLEAR)
//   cnt_sel_o    spike counter select (scan index during SCAN, else 0)
//   cnt_i        selected counter value, combinational from cnt_sel_o
//   busy_o       high in every state except IDLE
//   done_o       one-cycle pulse when class_o/max_count_o are updated
//   class_o      winning class index
//   max_count_o  spike count of the winning class
// ---------------------------------------------------------------------------
module snn_inference_ctrl #(
  parameter int WIDTH_P      = 8,
  parameter int NUM_CLASSES  = 10,
  parameter int NUM_STEPS    = 64,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic [WIDTH_P-1:0] pattern_i,
  output logic [WIDTH_P-1:0] stim_o,
  output logic               net_en_o,
  output logic               net_clr_o,
  output logic [3:0]         cnt_sel_o,
  input  logic [WIDTH_P-1:0] cnt_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [3:0]         class_o,
  output logic [WIDTH_P-1:0] max_count_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DRAIN,
    S_SCAN,
    S_DONE
  } state_t;

  state_t             state;
  logic [WIDTH_P-1:0] pattern_q;
  logic [7:0]         step_cnt;
  logic [3:0]         scan_idx;
  logic [WIDTH_P-1:0] best_val;
  logic [3:0]         best_idx;

  logic               take;
  logic [WIDTH_P-1:0] best_val_nxt;
  logic [3:0]         best_idx_nxt;

  // The scan index register drives the counter mux directly, so the value
  // on cnt_i always belongs to the index being evaluated this cycle.
  assign cnt_sel_o = scan_idx;

  // Running argmax. The first scan cycle seeds the best registers; later
  // cycles replace only on a strictly greater (unsigned) count, which keeps
  // ties on the lowest index.
  always_comb begin
    take         = (scan_idx == 4'd0) || (cnt_i > best_val);
    best_val_nxt = best_val;
    best_idx_nxt = best_idx;
    if (take) begin
      best_val_nxt = cnt_i;
      best_idx_nxt = scan_idx;
    end
  end

  // All outputs are registered: each transition sets the outputs that belong
  // to the state being entered.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= S_IDLE;
      pattern_q   <= '0;
      step_cnt    <= '0;
      scan_idx    <= '0;
      best_val    <= '0;
      best_idx    <= '0;
      stim_o      <= '0;
      net_en_o    <= 1'b0;
      net_clr_o   <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      class_o     <= '0;
      max_count_o <= '0;
    end else if (abort_i && (state != S_IDLE)) begin
      // Abort wins over every transition; the previous result is kept.
      state     <= S_IDLE;
      step_cnt  <= '0;
      scan_idx  <= '0;
      stim_o    <= '0;
      net_en_o  <= 1'b0;
      net_clr_o <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i) begin
            pattern_q <= pattern_i;
            state     <= S_CLEAR;
            net_clr_o <= 1'b1;
            busy_o    <= 1'b1;
          end
        end

        S_CLEAR: begin
          state     <= S_RUN;
          net_clr_o <= 1'b0;
          net_en_o  <= 1'b1;
          stim_o    <= pattern_q;
          step_cnt  <= '0;
        end

        S_RUN: begin
          if (step_cnt == 8'(NUM_STEPS - 1)) begin
            step_cnt <= '0;
            stim_o   <= '0;
            if (DRAIN_CYCLES == 0) begin
              state    <= S_SCAN;
              net_en_o <= 1'b0;
              scan_idx <= '0;
            end else begin
              state <= S_DRAIN;
            end
          end else begin
            step_cnt <= step_cnt + 8'd1;
          end
        end

        S_DRAIN: begin
          if (step_cnt == 8'(DRAIN_CYCLES - 1)) begin
            step_cnt <= '0;
            state    <= S_SCAN;
            net_en_o <= 1'b0;
            scan_idx <= '0;
          end else begin
            step_cnt <= step_cnt + 8'd1;
          end
        end

        S_SCAN: begin
          best_val <= best_val_nxt;
          best_idx <= best_idx_nxt;
          if (scan_idx == 4'(NUM_CLASSES - 1)) begin
            state       <= S_DONE;
            scan_idx    <= '0;
            done_o      <= 1'b1;
            class_o     <= best_idx_nxt;
            max_count_o <= best_val_nxt;
          end else begin
            scan_idx <= scan_idx + 4'd1;
          end
        end

        S_DONE: begin
          state  <= S_IDLE;
          done_o <= 1'b0;
          busy_o <= 1'b0;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snn_inference_ctrl.sv
// ---------------------------------------------------------------------------
// tb_snn_inference_ctrl
//
// Directed bench for snn_inference_ctrl with NUM_STEPS=4, DRAIN_CYCLES=2,
// NUM_CLASSES=10. A behavioural counter bank answers cnt_sel_o from a table.
// Each issued inference pushes its hand-computed result and start cycle into
// a queue; a monitor pops and compares whenever done_o is seen.
// ---------------------------------------------------------------------------
module tb_snn_inference_ctrl;

  localparam int W   = 8;
  localparam int NC  = 10;
  localparam int NS  = 4;
  localparam int DC  = 2;
  localparam int LAT = 1 + NS + DC + NC + 1;  // start negedge to done negedge

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_i = 1'b0;
  logic         abort_i = 1'b0;
  logic [W-1:0] pattern_i = '0;
  logic [W-1:0] stim_o;
  logic         net_en_o;
  logic         net_clr_o;
  logic [3:0]   cnt_sel_o;
  logic [W-1:0] cnt_i;
  logic         busy_o;
  logic         done_o;
  logic [3:0]   class_o;
  logic [W-1:0] max_count_o;

  logic [W-1:0] cnt_tab [NC];
  int           cyc = 0;
  int           checks = 0;
  int           errors = 0;

  typedef struct {
    logic [3:0]   cls;
    logic [W-1:0] mx;
    int           sc;
  } exp_t;
  exp_t exp_q[$];

  snn_inference_ctrl #(
    .WIDTH_P(W), .NUM_CLASSES(NC), .NUM_STEPS(NS), .DRAIN_CYCLES(DC)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_i), .abort_i(abort_i),
    .pattern_i(pattern_i), .stim_o(stim_o), .net_en_o(net_en_o),
    .net_clr_o(net_clr_o), .cnt_sel_o(cnt_sel_o), .cnt_i(cnt_i),
    .busy_o(busy_o), .done_o(done_o), .class_o(class_o),
    .max_count_o(max_count_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign cnt_i = (cnt_sel_o < 4'(NC)) ? cnt_tab[cnt_sel_o] : '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] obs();
    return {busy_o, net_clr_o, net_en_o, stim_o, cnt_sel_o, done_o};
  endfunction

  // busy, clr, en, stim, sel, done for negedge k after the start edge
  function automatic logic [15:0] nominal_exp(input int k);
    logic [15:0] v;
    v = '0;
    if (k == 0)                v = {1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0};
    else if (k >= 1 && k <= 4) v = {1'b1, 1'b0, 1'b1, 8'hA5, 4'd0, 1'b0};
    else if (k == 5 || k == 6) v = {1'b1, 1'b0, 1'b1, 8'h00, 4'd0, 1'b0};
    else if (k >= 7 && k <= 16) v = {1'b1, 1'b0, 1'b0, 8'h00, 4'(k - 7), 1'b0};
    else if (k == 17)          v = {1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 1'b1};
    return v;
  endfunction

  task automatic load_tab(input logic [W-1:0] v0, v1, v2, v3, v4, v5, v6, v7, v8, v9);
    cnt_tab[0] = v0; cnt_tab[1] = v1; cnt_tab[2] = v2; cnt_tab[3] = v3;
    cnt_tab[4] = v4; cnt_tab[5] = v5; cnt_tab[6] = v6; cnt_tab[7] = v7;
    cnt_tab[8] = v8; cnt_tab[9] = v9;
  endtask

  // Called at a negedge while idle; returns at the negedge after the start edge.
  task automatic run_start(input logic [W-1:0] pat, input logic [3:0] ec,
                           input logic [W-1:0] em, input bit push);
    exp_t e;
    pattern_i = pat;
    start_i   = 1'b1;
    if (push) begin
      e.cls = ec; e.mx = em; e.sc = cyc;
      exp_q.push_back(e);
    end
    @(negedge clk);
    start_i = 1'b0;
  endtask

  // Returns at the negedge on which done_o is high.
  task automatic wait_done();
    int n;
    n = 0;
    while (!done_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("done_timeout", 32'd0, 32'd1);
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst_n && done_o) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("class", 32'(class_o), 32'(e.cls));
        check("max_count", 32'(max_count_o), 32'(e.mx));
        check("latency", 32'(cyc - e.sc), 32'(LAT));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    load_tab(8'd3, 8'd7, 8'd2, 8'd9, 8'd9, 8'd0, 8'd1, 8'd4, 8'd8, 8'd5);

    // Reset state
    #3;
    check("reset_obs", 32'(obs()), 32'd0);
    check("reset_class", 32'(class_o), 32'd0);
    check("reset_max", 32'(max_count_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_busy", 32'(busy_o), 32'd0);
    check("idle_en", 32'(net_en_o), 32'd0);

    // Nominal timing with pattern A5; argmax with tie at 3/4
    pattern_i = 8'hA5;
    start_i   = 1'b1;
    e.cls = 4'd3; e.mx = 8'd9; e.sc = cyc;
    exp_q.push_back(e);
    for (int k = 0; k <= 18; k++) begin
      @(negedge clk);
      if (k == 0) start_i = 1'b0;
      check($sformatf("wave_k%0d", k), 32'(obs()), 32'(nominal_exp(k)));
    end

    // All counts zero
    load_tab(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    run_start(8'h3C, 4'd0, 8'd0, 1'b1);
    wait_done();
    @(negedge clk);

    // Only the last class fires, at full scale
    cnt_tab[9] = 8'd255;
    run_start(8'hFF, 4'd9, 8'd255, 1'b1);
    wait_done();
    @(negedge clk);

    // All equal: tie resolves to index 0
    load_tab(8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5);
    run_start(8'h01, 4'd0, 8'd5, 1'b1);
    wait_done();
    @(negedge clk);

    // Start pulses while busy are ignored; start in first idle cycle is taken
    load_tab(8'd3, 8'd7, 8'd2, 8'd9, 8'd9, 8'd0, 8'd1, 8'd4, 8'd8, 8'd5);
    run_start(8'h5A, 4'd3, 8'd9, 1'b1);
    repeat (2) @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    wait_done();
    load_tab(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd255);
    start_i = 1'b1;
    @(negedge clk);
    check("done_cycle_start_ignored", 32'(busy_o), 32'd0);
    e.cls = 4'd9; e.mx = 8'd255; e.sc = cyc;
    exp_q.push_back(e);
    @(negedge clk);
    start_i = 1'b0;
    check("idle_start_taken", 32'(net_clr_o), 32'd1);
    wait_done();
    @(negedge clk);

    // Abort during SCAN at k=5: no done, previous result kept
    load_tab(8'd3, 8'd7, 8'd2, 8'd9, 8'd9, 8'd0, 8'd1, 8'd4, 8'd8, 8'd5);
    run_start(8'hA5, 4'd0, 8'd0, 1'b0);
    begin
      int n;
      n = 0;
      while (cnt_sel_o != 4'd5 && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (n >= 100) check("scan_k5_timeout", 32'd0, 32'd1);
    end
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    check("abort_obs", 32'(obs()), 32'd0);
    check("abort_class", 32'(class_o), 32'd9);
    check("abort_max", 32'(max_count_o), 32'd255);
    repeat (25) @(negedge clk);
    check("abort_hold_class", 32'(class_o), 32'd9);
    check("abort_hold_busy", 32'(busy_o), 32'd0);

    // Async reset mid-RUN at step 2
    run_start(8'hC3, 4'd0, 8'd0, 1'b0);
    repeat (3) @(negedge clk);
    check("run_step2_stim", 32'(stim_o), 32'hC3);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_obs", 32'(obs()), 32'd0);
    check("midreset_class", 32'(class_o), 32'd0);
    check("midreset_max", 32'(max_count_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("post_reset_busy", 32'(busy_o), 32'd0);
    check("post_reset_en", 32'(net_en_o), 32'd0);
    check("post_reset_class", 32'(class_o), 32'd0);

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
